// File: rtl/wfetch_pkg.sv
// Shared types and constants for the weight fetch controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package wfetch_pkg;

  localparam int WORD_W = 13;  // INT_BITS + FRC_BITS at default sizing
  localparam int ROWS   = 28;
  localparam int DEPTH  = 32;

  typedef logic [WORD_W-1:0]      weight_t;
  typedef weight_t [ROWS-1:0]     wvec_t;  // lane n sits at bits [n*WORD_W +: WORD_W]

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/wfetch_skid_fifo.sv
// Two-entry skid FIFO holding {vector, index, last} captured from the ROM.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module wfetch_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0, mem1;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   cnt;
  logic         wr_en, rd_en;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign dout  = rd_ptr ? mem1 : mem0;
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage and pointers; storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_en) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams len weight vectors out of a parallel ROM bank (registered read) through a 2-entry skid FIFO.
// Latency: start at cycle 0 -> rom_addr 0 at cycle 1 -> first w_valid at cycle 3, then one vector per cycle.
// Backpressure: w_ready low stalls address issue via occupancy credit; optional WFETCH_SIGNATURE_EN adds sig.
module weight_fetch_ctrl #(
  parameter int INT_BITS = 6,
  parameter int FRC_BITS = 7,
  parameter int ROWS     = 28,
  parameter int DEPTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(DEPTH):0]               len,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(DEPTH)-1:0]             rom_addr,
  input  logic [ROWS*(INT_BITS+FRC_BITS)-1:0]  rom_dout,
  output logic                                 w_valid,
  input  logic                                 w_ready,
  output logic [ROWS*(INT_BITS+FRC_BITS)-1:0]  w_data,
  output logic [$clog2(DEPTH)-1:0]             w_index,
  output logic                                 w_last
`ifdef WFETCH_SIGNATURE_EN
  ,
  output logic [INT_BITS+FRC_BITS-1:0]         sig
`endif
);

  import wfetch_pkg::*;

  localparam int WW = INT_BITS + FRC_BITS;
  localparam int VW = ROWS * WW;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = VW + AW + 1;

  state_t         state;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  len_clamped;
  logic [LW-1:0]  issue_cnt;   // next address to issue
  logic [AW-1:0]  last_addr;   // most recently issued address
  logic           inf_vld;     // an address was issued last cycle; its data is on rom_dout now
  logic [AW-1:0]  inf_idx;
  logic           inf_last;

  logic [PW-1:0]  fifo_head;
  logic           fifo_full, fifo_empty;
  logic [1:0]     occ;
  logic [2:0]     pending;
  logic           pop, issue, issue_last;

  assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

  assign w_valid = !fifo_empty;
  assign pop     = w_valid && w_ready;
  assign {w_data, w_index, w_last} = fifo_head;

  // Credit check: words already held or on their way, minus the one leaving now, must leave room.
  assign occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pending    = {1'b0, occ} + {2'b0, inf_vld} - {2'b0, pop};
  assign issue      = (state == FETCH) && (issue_cnt < len_q) && (pending < 3'd2);
  assign issue_last = issue && (issue_cnt == len_q - 1'b1);

  // The ROM registers its address, so the issued address is presented in the issue cycle itself.
  assign rom_addr = issue ? issue_cnt[AW-1:0] : last_addr;

  wfetch_skid_fifo #(.W(PW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inf_vld),
    .pop   (pop),
    .din   ({rom_dout, inf_idx, inf_last}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pass control FSM with registered busy/done, address counter and in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      issue_cnt <= '0;
      last_addr <= '0;
      inf_vld   <= 1'b0;
      inf_idx   <= '0;
      inf_last  <= 1'b0;
    end else begin
      inf_vld  <= issue;
      inf_idx  <= issue_cnt[AW-1:0];
      inf_last <= issue_last;
      if (issue) begin
        last_addr <= issue_cnt[AW-1:0];
        issue_cnt <= issue_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len_clamped;
            issue_cnt <= '0;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && w_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WFETCH_SIGNATURE_EN
  logic [WW-1:0] lane_xor;

  // XOR of every lane of the vector currently at the FIFO head.
  always_comb begin
    lane_xor = '0;
    for (int r = 0; r < ROWS; r++) lane_xor = lane_xor ^ w_data[r*WW +: WW];
  end

  // Running signature over popped vectors; restarts with each accepted pass.
  always_ff @(posedge clk) begin
    if (rst)                          sig <= '0;
    else if (state == IDLE && start)  sig <= '0;
    else if (pop)                     sig <= sig ^ lane_xor;
  end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: ROM model, expected-vector queue, table of passes.
// Latency: checks rom_addr at cycle 1, first w_valid at cycle 3, done cycle per pass.
// Backpressure: drives steady, toggling and random w_ready patterns.
module tb_weight_fetch_ctrl;
  import wfetch_pkg::*;

  localparam int VW = ROWS * WORD_W;
  localparam int CW = VW + 6;

  typedef struct packed {
    logic [4:0]    idx;
    logic          last;
    logic [VW-1:0] dat;
  } exp_t;

  typedef struct {
    int len;
    int mode;       // 0: ready high, 1: toggling, 2: random
    bit restart;    // re-pulse start with len=3 while busy
    int exp_done;   // expected done cycle, -1 = not checked
    int rst_after;  // assert rst after this many handshakes, 0 = never
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, start, w_ready;
  logic [5:0]      len;
  logic            busy, done, w_valid, w_last;
  logic [4:0]      rom_addr, w_index;
  logic [VW-1:0]   rom_dout, w_data;
`ifdef WFETCH_SIGNATURE_EN
  logic [WORD_W-1:0] sig;
`endif

  wvec_t mem [DEPTH];
  exp_t  q[$];
  vec_t  tbl [6];
  int    total = 0;
  int    bad   = 0;

  weight_fetch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_index  (w_index),
    .w_last   (w_last)
`ifdef WFETCH_SIGNATURE_EN
    ,
    .sig      (sig)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // ROM bank: one-cycle registered read, no enable.
  always @(posedge clk) rom_dout <= mem[rom_addr];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, CW'({busy, done, w_valid, w_last, rom_addr, w_index}), CW'(0));
    chk({name, "_data"}, CW'(w_data), CW'(0));
  endtask

  task automatic run_pass(input int L, input int mode, input bit restart,
                          input int exp_done, input int rst_after);
    int n, cyc, hs, done_cyc, first_v;
    bit done_seen, do_rst, aborted;
    logic [WORD_W-1:0] xs;
    n = (L > DEPTH) ? DEPTH : L;
    @(posedge clk); #1;
    start = 1'b1; len = 6'(L); w_ready = 1'b1;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back('{idx: 5'(i), last: (i == n - 1), dat: mem[i]});
    cyc = 0; hs = 0; done_seen = 0; done_cyc = -1; first_v = -1; do_rst = 0; aborted = 0;
    while (!done_seen && !aborted && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = restart && (cyc == 2);
      len   = (restart && cyc == 2) ? 6'd3 : 6'(L);
      if (do_rst) begin
        rst = 1'b1; w_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("midpass_rst");
        q.delete();
        aborted = 1;
      end else begin
        case (mode)
          0:       w_ready = 1'b1;
          1:       w_ready = (cyc % 2 == 1);
          default: w_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        if (cyc == 1 && n > 0) chk("addr0_at_cycle1", CW'(rom_addr), CW'(0));
        if (done) begin
          done_seen = 1;
          done_cyc  = cyc;
`ifdef WFETCH_SIGNATURE_EN
          xs = '0;
          for (int i = 0; i < n; i++)
            for (int r = 0; r < ROWS; r++) xs = xs ^ mem[i][r];
          chk("sig", CW'(sig), CW'(xs));
`endif
        end
        chk("busy", CW'(busy), CW'((n != 0) && !done_seen));
        if (w_valid) begin
          if (first_v < 0) first_v = cyc;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_vector: got index %0d want none", w_index);
          end else begin
            chk("vec", {w_index, w_last, w_data}, q[0]);
            if (w_ready) begin
              void'(q.pop_front());
              hs++;
              if (rst_after > 0 && hs == rst_after) do_rst = 1;
            end
          end
        end
      end
    end
    if (!aborted) begin
      if (!done_seen) begin
        total++; bad++;
        $display("FAIL done_timeout: got no done in %0d cycles want done", cyc);
      end
      if (exp_done >= 0) chk("done_cycle", CW'(done_cyc), CW'(exp_done));
      if (mode == 0 && n > 0) chk("first_valid_cycle", CW'(first_v), CW'(3));
      chk("leftover", CW'(q.size()), CW'(0));
      @(posedge clk); #1;
      w_ready = 1'b1;
      @(negedge clk);
      chk("done_one_cycle", CW'({done, busy, w_valid}), CW'(0));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; w_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++)
      for (int r = 0; r < ROWS; r++) mem[a][r] = WORD_W'($urandom);

    tbl[0] = '{len: 32, mode: 0, restart: 0, exp_done: 35, rst_after: 0};
    tbl[1] = '{len: 5,  mode: 1, restart: 0, exp_done: -1, rst_after: 0};
    tbl[2] = '{len: 0,  mode: 0, restart: 0, exp_done: 1,  rst_after: 0};
    tbl[3] = '{len: 6,  mode: 0, restart: 1, exp_done: 9,  rst_after: 0};
    tbl[4] = '{len: 40, mode: 0, restart: 0, exp_done: 35, rst_after: 0};
    tbl[5] = '{len: 7,  mode: 2, restart: 0, exp_done: -1, rst_after: 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run_pass(tbl[t].len, tbl[t].mode, tbl[t].restart, tbl[t].exp_done, tbl[t].rst_after);

    // rst together with start: the start must be dropped.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; len = 6'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_start_idle", CW'({busy, done, w_valid}), CW'(0));
      @(posedge clk); #1;
    end

    // Reset in the cycle after the 4th handshake, then a fresh short pass.
    run_pass(10, 0, 0, -1, 4);
    run_pass(2, 0, 0, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
